// File: rtl/window_assembler.sv
// -----------------------------------------------------------------------------
// window_assembler
//   Builds a W_W x W_H pixel window from the vertical columns produced by the
//   row line buffer. It shifts one column per accepted beat and tracks the raster
//   position of the newest pixel. It flags windows that lie fully inside the frame.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   en         column-valid strobe; col_in is accepted on each rising edge with en=1
//   sof        start of frame, qualified by en; the accepted pixel becomes (0,0)
//   col_in     W_H*8 column taps, [7:0] = current row, byte r = r rows above
//   win        W_W*W_H*8 window, pixel (c,r) at [(c*W_H+r)*8 +: 8], c/r=0 newest
//   win_valid  one-cycle pulse when the accepted pixel's window is fully in-frame
//   win_x      column index of the newest pixel in the window
//   win_y      row index of the newest pixel in the window
// -----------------------------------------------------------------------------

// One window column: a plain enabled register.
module wa_col_reg #(
    parameter int W = 40
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)    q <= '0;
        else if (en) q <= d;
    end
endmodule

module window_assembler #(
    parameter int W_H     = 5,
    parameter int W_W     = 5,
    parameter int ROW_LEN = 2048,
    parameter int YW      = 12,
    // A single-pixel row still needs a 1-bit x counter.
    localparam int XW     = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1,
    localparam int CW     = W_H * 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  sof,
    input  logic [CW-1:0]         col_in,
    output logic [W_W*CW-1:0]     win,
    output logic                  win_valid,
    output logic [XW-1:0]         win_x,
    output logic [YW-1:0]         win_y
);
    localparam logic [XW-1:0] X_LAST = XW'(ROW_LEN - 1);
    localparam logic [YW-1:0] Y_MAX  = '1;

    // ---------------- column shift array ----------------
    logic [W_W-1:0][CW-1:0] cols;
    logic [W_W-1:0][CW-1:0] col_d;

    generate
        if (W_W == 1) begin : g_one
            assign col_d = col_in;
        end else begin : g_many
            // Column 0 takes the new column; column c takes column c-1.
            assign col_d = {cols[W_W-2:0], col_in};
        end

        for (genvar c = 0; c < W_W; c++) begin : g_col
            wa_col_reg #(.W(CW)) u_col (
                .clk (clk),
                .rst (rst),
                .en  (en),
                .d   (col_d[c]),
                .q   (cols[c])
            );
        end
    endgenerate

    assign win = cols;

    // ---------------- position tracking ----------------
    // x_q/y_q hold the position the next accepted pixel will take.
    logic [XW-1:0] x_q, pix_x, nxt_x;
    logic [YW-1:0] y_q, pix_y, nxt_y;
    logic          pix_in;

    always_comb begin
        // sof overrides the counters, so a mid-frame sof resyncs immediately.
        pix_x = sof ? '0 : x_q;
        pix_y = sof ? '0 : y_q;
        nxt_x = pix_x + XW'(1);
        nxt_y = pix_y;
        if (pix_x == X_LAST) begin
            nxt_x = '0;
            // Saturate rather than wrap so a runaway stream never aliases row 0.
            nxt_y = (pix_y == Y_MAX) ? pix_y : pix_y + YW'(1);
        end
        pix_in = (32'(pix_x) >= 32'(W_W - 1)) && (32'(pix_y) >= 32'(W_H - 1));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_q       <= '0;
            y_q       <= '0;
            win_x     <= '0;
            win_y     <= '0;
            win_valid <= 1'b0;
        end else begin
            win_valid <= en && pix_in;
            if (en) begin
                x_q   <= nxt_x;
                y_q   <= nxt_y;
                win_x <= pix_x;
                win_y <= pix_y;
            end
        end
    end
endmodule

// File: tb/tb_window_assembler.sv
// -----------------------------------------------------------------------------
// tb_window_assembler
//   Directed bench for window_assembler with a 5x5 window, 8-pixel rows and a
//   3-bit row counter. It covers reset, window shift, valid gating, gapped
//   enables, row wrap with y saturation, and mid-frame sof resync.
// -----------------------------------------------------------------------------
module tb_window_assembler;
    localparam int W_H = 5, W_W = 5, ROW_LEN = 8, YW = 3;
    localparam int CW = W_H * 8, WW = W_W * CW;

    logic          clk = 1'b0, rst = 1'b1, en = 1'b0, sof = 1'b0;
    logic [CW-1:0] col_in = '0;
    logic [WW-1:0] win;
    logic          win_valid;
    logic [2:0]    win_x;
    logic [YW-1:0] win_y;

    int total = 0, bad = 0, pulses = 0;

    // Expected state: shifted column history and the last accepted position.
    logic [WW-1:0] exp_win = '0;
    int            exp_x = 0, exp_y = 0;
    logic          exp_v = 1'b0;

    window_assembler #(.W_H(W_H), .W_W(W_W), .ROW_LEN(ROW_LEN), .YW(YW)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .sof       (sof),
        .col_in    (col_in),
        .win       (win),
        .win_valid (win_valid),
        .win_x     (win_x),
        .win_y     (win_y)
    );

    always #5 clk = ~clk;

    // Pixel value at (x,y) is 8*y+x. Byte r of the column is the pixel r rows up.
    function automatic logic [CW-1:0] colv(input int x, input int y);
        logic [CW-1:0] v;
        v = '0;
        for (int r = 0; r < W_H; r++) v[r*8 +: 8] = 8'(8*(y-r) + x);
        return v;
    endfunction

    function automatic logic [WW-1:0] winv(input int x, input int y);
        logic [WW-1:0] v;
        v = '0;
        for (int c = 0; c < W_W; c++)
            for (int r = 0; r < W_H; r++)
                v[(c*W_H+r)*8 +: 8] = 8'(8*(y-r) + (x-c));
        return v;
    endfunction

    task automatic chk(input string tag, input logic [WW-1:0] o, input logic [WW-1:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic check_outs();
        chk("win",       win,             exp_win);
        chk("win_x",     WW'(win_x),      WW'(exp_x));
        chk("win_y",     WW'(win_y),      WW'(exp_y));
        chk("win_valid", WW'(win_valid),  WW'(exp_v));
    endtask

    task automatic zero_model();
        exp_win = '0;
        exp_x   = 0;
        exp_y   = 0;
        exp_v   = 1'b0;
    endtask

    // One cycle: drive at negedge, check #1 after the following posedge.
    // ex/ey give the hand-computed position of the pixel on an accept beat.
    task automatic beat(input logic e, input logic s, input logic [CW-1:0] c,
                        input int ex, input int ey);
        @(negedge clk);
        en     = e;
        sof    = s;
        col_in = c;
        if (e) begin
            exp_win = {exp_win[WW-CW-1:0], c};
            exp_x   = ex;
            exp_y   = ey;
            exp_v   = (ex >= W_W-1) && (ey >= W_H-1);
        end else begin
            exp_v   = 1'b0;
        end
        @(posedge clk);
        #1;
        check_outs();
        if (win_valid) pulses++;
    endtask

    initial begin
        // ---- power-on reset ----
        #2 rst = 1'b0;
        zero_model();
        #1 check_outs();
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b1;

        // Load some non-zero state first.
        beat(1'b1, 1'b0, 40'h11_2233_4455, 0, 0);
        beat(1'b1, 1'b0, 40'hAA_BBCC_DDEE, 1, 0);
        beat(1'b1, 1'b0, 40'h01_0203_0405, 2, 0);

        // ---- asynchronous reset mid-clock with en toggling ----
        @(negedge clk);
        en = 1'b1;
        col_in = 40'hDE_ADBE_EF00;
        @(posedge clk);
        #2 en = 1'b0;
        #1 rst = 1'b0;
        zero_model();
        #1 check_outs();
        repeat (3) @(negedge clk) en = ~en;
        #1 check_outs();
        @(negedge clk);
        en = 1'b0;
        rst = 1'b1;
        beat(1'b1, 1'b1, 40'hA5_A5A5_A5A5, 0, 0);

        // ---- gap-free frame ----
        pulses = 0;
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 8; x++) begin
                beat(1'b1, (x == 0 && y == 0), colv(x, y), x, y);
                if (x >= 4 && y >= 4) chk("win_formula", win, winv(x, y));
                if (x == 4 && y == 4) begin
                    chk("c0r0_at_4_4", WW'(win[7:0]), WW'(36));
                    chk("c4r4_at_4_4", WW'(win[(4*W_H+4)*8 +: 8]), WW'(0));
                end
            end
        chk("pulses_nogap", WW'(pulses), WW'(16));

        // ---- gapped frame: bubbles with random data and sof ----
        pulses = 0;
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 8; x++) begin
                if ($urandom_range(0, 1) == 1) begin
                    for (int g = $urandom_range(1, 3); g > 0; g--)
                        beat(1'b0, 1'($urandom_range(0, 1)), CW'({$urandom, $urandom}), 0, 0);
                end
                beat(1'b1, (x == 0 && y == 0), colv(x, y), x, y);
                if (x >= 4 && y >= 4) chk("win_formula_gap", win, winv(x, y));
            end
        chk("pulses_gap", WW'(pulses), WW'(16));

        // ---- mid-frame resync at pixel (5,6) ----
        for (int i = 0; i < 53; i++)
            beat(1'b1, (i == 0), colv(i % 8, i / 8), i % 8, i / 8);
        beat(1'b1, 1'b1, colv(5, 6), 0, 0);
        beat(1'b1, 1'b0, colv(6, 6), 1, 0);

        // ---- reset, then 80 pixels without sof: row wrap and y saturation ----
        @(negedge clk);
        en = 1'b0;
        rst = 1'b0;
        zero_model();
        #1 check_outs();
        @(negedge clk) rst = 1'b1;
        for (int i = 0; i < 80; i++)
            beat(1'b1, 1'b0, colv(i % 8, i / 8), i % 8, (i / 8 > 7) ? 7 : i / 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
